multi_nxn_seq: RTL
==================

// Module: multi_nxn_seq
// PURPOSE
//   Parametrised sequential shift-add multiplier, the successor to the fixed 16x16 ALU multiplier.
//   Processes K multiplier bits per clock and supports signed or unsigned mode, selected per operation.
//   Sits in the ALU behind a start/done_flag handshake.
//   Can also drive a 7-segment digit showing the result (optional feature).
// PARAMETERS
//   WIDTH           16  operand width; product is 2*WIDTH bits
//   BITS_PER_CYCLE  1   multiplier bits consumed per CALC cycle (K); must be 1, 2 or 4, and WIDTH % K == 0
// PORTS
//   clk               in   1        single clock, rising edge
//   reset_a           in   1        reset; synchronous, active-high
//   start             in   1        request; sampled only in IDLE
//   signed_mode       in   1        1 = two's-complement operands; latched with start
//   dataa             in   WIDTH    multiplicand; latched with start
//   datab             in   WIDTH    multiplier; latched with start
//   busy              out  1        high while the state is CALC or FIX
//   done_flag         out  1        one-cycle pulse when product_out updates
//   product_out       out  2*WIDTH  result; held until the next done_flag
//   seg_a..seg_g      out  1 each   7-segment outputs, active-high (see CONFIGURATION)
// BEHAVIOUR
//   Reset (edge with reset_a=1), including mid-operation:
//     - state=IDLE; busy=0, done_flag=0, product_out=0, segs=0.
//     - Any in-flight operation is discarded and no done_flag is issued.
//   FSM states: IDLE -> CALC -> FIX -> IDLE.
//   IDLE:
//     - start=1 at an edge latches dataa, datab and signed_mode, then enters CALC.
//     - Latched operands are magnitudes: in signed mode the absolute value, as a WIDTH-bit unsigned number.
//     - neg = sign(a) XOR sign(b), signed mode only.
//     - |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact in WIDTH unsigned bits.
//     - The accumulator clears and the iteration counter loads C = WIDTH/K.
//   CALC:
//     - Each edge: acc += mcand * mplier[K-1:0] << (shift); mplier >>= K; counter decrements.
//     - The accumulator is 2*WIDTH bits wide and never overflows.
//     - Leaves for FIX after exactly C edges.
//   FIX:
//     - One edge: product_out = neg ? -acc : acc (2*WIDTH two's complement).
//     - On the same edge: done_flag=1 and state=IDLE.
//   done_flag:
//     - High for exactly one cycle, then 0 at the next edge.
//     - start sampled at that next edge is accepted, so back-to-back operations are allowed.
//   Latency:
//     - From the start-sampling edge to done_flag high is C+1 edges.
//     - WIDTH=16, K=1: 17 cycles. K=4: 5 cycles.
//   start while busy=1 is ignored; no queueing. Inputs may change freely once latched.
//   Unsigned mode: neg=0, no negation; operands are used raw.
//   A zero operand still takes the full latency (no early exit).
// CONFIGURATION
//   SEVEN_SEG_EN defined:
//     - seg_a..seg_g show the hex digit of product_out[3:0].
//     - Registered, updating on the same edge as product_out.
//   SEVEN_SEG_EN undefined:
//     - seg_a..seg_g are tied to 0.
//     - No decoder logic is instantiated; ports are unchanged.
// STRUCTURE
//   Package multi_pkg:
//     - state encoding localparams (IDLE=2'd0, CALC=2'd1, FIX=2'd2);
//     - function calc_cycles(width, k);
//     - the 16-entry hex-to-segment constant table.
//   Sub-module hex_to_7seg: 4-bit in, 7 segment outs, combinational, used only under SEVEN_SEG_EN.
//   Datapath: magnitude/sign capture, accumulator, counter, negation stage.
// TESTING
//   1. Unsigned 0x00FF*0xFEFF, K=1 -> product_out=0x00FE0001.
//      done_flag 17 edges after start; seg shows '1' (b,c lit) if SEVEN_SEG_EN.
//   2. Signed 0xFFFF*0x0002 -> 0xFFFFFFFE. Same operands unsigned -> 0x0001FFFE.
//   3. Signed 0x8000*0x7FFF -> 0xC0008000; signed 0x8000*0x8000 -> 0x40000000.
//   4. start held high continuously, K=4:
//      - done_flag every 6 cycles; start pulses during busy have no effect;
//      - product_out is stable between pulses.
//   5. reset_a asserted on the 5th CALC edge:
//      - next cycle: busy=0, product_out=0, no done_flag.
//      - A new start then completes normally.
//   6. WIDTH=8, K=2: random signed/unsigned sweep vs. a reference model.
//      done_flag always exactly 5 edges after start.

Source files
------------

// File: rtl/multi_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding,
// iteration-count helper and the hex-to-segment lookup table.
package multi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int calc_cycles(input int width, input int k);
        return width / k;
    endfunction

    // Segment patterns packed as {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-digit to 7-segment decoder (active-high segments).
module hex_to_7seg
    import multi_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic       o_seg_a,
    output logic       o_seg_b,
    output logic       o_seg_c,
    output logic       o_seg_d,
    output logic       o_seg_e,
    output logic       o_seg_f,
    output logic       o_seg_g
);

    logic [6:0] w_seg;

    assign w_seg = SEG_TABLE[i_hex];
    assign {o_seg_a, o_seg_b, o_seg_c, o_seg_d, o_seg_e, o_seg_f, o_seg_g} = w_seg;

endmodule

// File: rtl/multi_nxn_seq.sv
// Sequential shift-add multiplier, BITS_PER_CYCLE multiplier bits per CALC edge,
// signed or unsigned per operation. Optional SEVEN_SEG_EN drives a result digit.
module multi_nxn_seq
    import multi_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic                 busy,
    output logic                 done_flag,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 seg_a,
    output logic                 seg_b,
    output logic                 seg_c,
    output logic                 seg_d,
    output logic                 seg_e,
    output logic                 seg_f,
    output logic                 seg_g
);

    localparam int K      = BITS_PER_CYCLE;
    localparam int CYCLES = calc_cycles(WIDTH, K);
    localparam int CNT_W  = $clog2(CYCLES + 1);

    if (!(K == 1 || K == 2 || K == 4) || (WIDTH % K) != 0) begin : g_bad_param
        $error("multi_nxn_seq: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_digit;
    logic [2*WIDTH-1:0]   w_partial;
    logic [2*WIDTH-1:0]   w_result;
    logic                 w_accept;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_mag_a   = (signed_mode && dataa[WIDTH-1]) ? -dataa : dataa;
    assign w_mag_b   = (signed_mode && datab[WIDTH-1]) ? -datab : datab;
    assign w_digit   = {{(2*WIDTH-K){1'b0}}, r_mplier[K-1:0]};
    assign w_partial = r_mcand * w_digit;
    assign w_result  = r_neg ? -r_acc : r_acc;
    assign w_accept  = (r_state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (r_cnt == CNT_W'(1)) r_state <= FIX;
                end
                FIX: begin
                    r_product <= w_result;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on the
    // accepting edge before being consumed, so reset only costs routing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= CNT_W'(CYCLES);
        end else if (r_state == CALC) begin
            r_acc    <= r_acc + w_partial;
            r_mcand  <= r_mcand << K;
            r_mplier <= r_mplier >> K;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    assign busy        = r_busy;
    assign done_flag   = r_done;
    assign product_out = r_product;

`ifdef SEVEN_SEG_EN
    logic [6:0] w_seg;
    logic [6:0] r_seg;

    hex_to_7seg u_hex_to_7seg (
        .i_hex   (w_result[3:0]),
        .o_seg_a (w_seg[6]),
        .o_seg_b (w_seg[5]),
        .o_seg_c (w_seg[4]),
        .o_seg_d (w_seg[3]),
        .o_seg_e (w_seg[2]),
        .o_seg_f (w_seg[1]),
        .o_seg_g (w_seg[0])
    );

    always_ff @(posedge clk) begin
        if (reset_a) r_seg <= '0;
        else if (r_state == FIX) r_seg <= w_seg;
    end

    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = r_seg;
`else
    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = 7'b0;
`endif

endmodule
